// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared constants and types for the BIP control unit
//
// Purpose: opcode map, FSM state enum, accumulator/ALU select encodings,
//          decoded control bundle and default widths.
// Ports:   none (package).
package bip_pkg;

    localparam int PC_W_DEF   = 11;
    localparam int DATA_W_DEF = 16;
    localparam int OPC_W      = 5;
    localparam int CNT_W      = 16;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4
    } state_t;

    // Opcode-level controls; the FSM qualifies the enables with the state.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc_en;
        logic       wr_ram_en;
        logic       rd_ram_en;
        logic       is_hlt;
    } ctrl_t;

    // Run-cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - opcode to control-bundle decoder
//
// Purpose: purely combinational map from the 5-bit opcode to mux selects,
//          ALU op, write/read enables and the halt flag. Unlisted opcodes
//          decode to an all-zero bundle, i.e. a NOP.
// Ports:   i_opcode  in  5   instruction opcode IR[15:11]
//          o_ctrl    out     decoded ctrl_t bundle
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_t            o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OPC_HLT: begin
                o_ctrl.is_hlt = 1'b1;
            end
            OPC_STO: begin
                o_ctrl.wr_ram_en = 1'b1;
            end
            OPC_LD: begin
                o_ctrl.rd_ram_en = 1'b1;
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_RAM;
            end
            OPC_LDI: begin
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_IMM;
            end
            OPC_ADD: begin
                o_ctrl.rd_ram_en = 1'b1;
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = SELB_RAM;
                o_ctrl.op        = OP_ADD;
            end
            OPC_ADDI: begin
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = SELB_IMM;
                o_ctrl.op        = OP_ADD;
            end
            OPC_SUB: begin
                o_ctrl.rd_ram_en = 1'b1;
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = SELB_RAM;
                o_ctrl.op        = OP_SUB;
            end
            OPC_SUBI: begin
                o_ctrl.wr_acc_en = 1'b1;
                o_ctrl.sel_a     = SELA_ALU;
                o_ctrl.sel_b     = SELB_IMM;
                o_ctrl.op        = OP_SUB;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - multi-cycle control unit for the BIP datapath
//
// Purpose: fetch/decode/mem/exec sequencer that owns PC, IR and a saturating
//          run-cycle counter, and drives the accumulator datapath controls.
// Ports:   clk         in   1       system clock, rising edge
//          reset       in   1       synchronous, active-high reset
//          Start       in   1       begin execution at PC 0 (IDLE only)
//          ProgData    in   DATA_W  program memory data, one cycle after ProgAddr
//          ProgAddr    out  PC_W    program memory address (= PC)
//          DataAddr    out  PC_W    data memory address (= IR operand)
//          RdRam       out  1       data memory read strobe (MEM)
//          WrRam       out  1       data memory write strobe (EXEC of STO)
//          Imm         out  DATA_W  sign-extended IR operand
//          SelA        out  2       accumulator input mux select
//          SelB        out  1       ALU operand B select
//          Op          out  1       ALU operation, 0 add / 1 subtract
//          WrAcc       out  1       accumulator write enable
//          Busy        out  1       high whenever not IDLE
//          Done        out  1       one-cycle pulse after HLT retires
//          CycleCount  out  16      non-IDLE cycles since last Start
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] ProgData,
    output logic [PC_W-1:0]   ProgAddr,
    output logic [PC_W-1:0]   DataAddr,
    output logic              RdRam,
    output logic              WrRam,
    output logic [DATA_W-1:0] Imm,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              Op,
    output logic              WrAcc,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCount
);

    state_t             r_state;
    state_t             w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_ir;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               r_done;
    logic [OPC_W-1:0]   w_opcode;
    ctrl_t              w_ctrl;

    assign w_opcode = r_ir[DATA_W-1 -: OPC_W];

    bip_decoder u_decoder (
        .i_opcode (w_opcode),
        .o_ctrl   (w_ctrl)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC, IR, cycle counter and the Done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_cycle_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            // Done is the registered image of "HLT seen in MEM", so it lands
            // in the first IDLE cycle after the halt.
            r_done <= (r_state == ST_MEM) && w_ctrl.is_hlt;

            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_pc        <= '0;
                        r_cycle_cnt <= '0;
                    end
                end
                ST_DECODE: begin
                    r_ir <= ProgData;
                end
                ST_EXEC: begin
                    r_pc <= r_pc + PC_W'(1);
                end
                default: begin
                end
            endcase

            if (r_state != ST_IDLE) begin
                r_cycle_cnt <= sat_inc(r_cycle_cnt);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = Start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = ST_MEM;
            ST_MEM:    w_next_state = w_ctrl.is_hlt ? ST_IDLE : ST_EXEC;
            ST_EXEC:   w_next_state = ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: strobes and selects exist only in their own state.
    always_comb begin
        RdRam = 1'b0;
        WrRam = 1'b0;
        WrAcc = 1'b0;
        SelA  = 2'b00;
        SelB  = 1'b0;
        Op    = 1'b0;
        Busy  = (r_state != ST_IDLE);
        case (r_state)
            ST_MEM: begin
                RdRam = w_ctrl.rd_ram_en;
            end
            ST_EXEC: begin
                WrAcc = w_ctrl.wr_acc_en;
                WrRam = w_ctrl.wr_ram_en;
                SelA  = w_ctrl.sel_a;
                SelB  = w_ctrl.sel_b;
                Op    = w_ctrl.op;
            end
            default: begin
            end
        endcase
    end

    assign ProgAddr   = r_pc;
    assign DataAddr   = r_ir[PC_W-1:0];
    assign Imm        = {{(DATA_W-PC_W){r_ir[PC_W-1]}}, r_ir[PC_W-1:0]};
    assign Done       = r_done;
    assign CycleCount = r_cycle_cnt;

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Multi-cycle control unit for the single-accumulator BIP datapath. It fetches 16-bit instructions from program memory, decodes them, and sequences the accumulator write enable, the accumulator input mux, the ALU operation and data-memory accesses. It owns the program counter and a run-cycle counter, and exposes a Start/Done handshake to the top level.

## Interface
Parameters:
- PC_W, 11, program counter / data address width
- DATA_W, 16, instruction and data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  begin execution at PC 0; sampled only in IDLE
- ProgData  in  16  program memory read data, valid one cycle after ProgAddr
- ProgAddr  out  11  program memory address (= PC)
- DataAddr  out  11  data memory address (= IR[10:0])
- RdRam  out  1  data memory read strobe
- WrRam  out  1  data memory write strobe (stores accumulator)
- Imm  out  16  IR[10:0] sign-extended to 16 bits
- SelA  out  2  accumulator input mux: 00 data RAM, 01 Imm, 10 ALU result
- SelB  out  1  ALU operand B: 0 data RAM, 1 Imm
- Op  out  1  ALU operation: 0 add, 1 subtract
- WrAcc  out  1  accumulator write enable
- Busy  out  1  high whenever state is not IDLE
- Done  out  1  one-cycle pulse after HLT retires
- CycleCount  out  16  cycles spent executing since last Start

## Operation
- ISA: opcode IR[15:11], operand IR[10:0]. 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI; all other opcodes are NOPs.
- States: IDLE, FETCH, DECODE, MEM, EXEC.
- IDLE: all strobes low. Start=1 -> PC<=0, CycleCount<=0, next FETCH.
- FETCH: ProgAddr=PC; next DECODE.
- DECODE: IR<=ProgData at end of cycle; next MEM.
- MEM: if HLT -> next IDLE, Done registered high for the following cycle. Otherwise RdRam=1 for LD/ADD/SUB; next EXEC.
- EXEC: LD: SelA=00, WrAcc. LDI: SelA=01, WrAcc. ADD/SUB: SelA=10, SelB=0, Op=0/1, WrAcc. ADDI/SUBI: SelA=10, SelB=1, Op=0/1, WrAcc. STO: WrRam=1. NOP: no strobes. PC<=PC+1 (wraps 0x7FF->0x000); next FETCH.
- Strobes and mux selects are decoded from state and IR; outside their stated state, selects are 0 and strobes are low.
- CycleCount increments every non-IDLE cycle and saturates at 0xFFFF.
- Start while Busy is ignored. On HLT, PC is left pointing at the HLT and CycleCount holds until the next Start.

## Timing
- Reset: state IDLE; PC, IR, CycleCount = 0; all outputs 0 (Imm=0, ProgAddr=0).
- Reset takes effect on the clock edge regardless of state. The cycle after a reset in EXEC has WrAcc=WrRam=0.
- Non-HLT instruction: 4 cycles. HLT: 3 cycles (FETCH, DECODE, MEM), then the Done cycle, in which the state is IDLE.
- Data RAM read latency is 1: the read issued in MEM is valid in EXEC.
- Done and Start in the same IDLE cycle: the run starts; Done is still emitted.

## Structure
- bip_pkg: opcode constants, state enum, SelA/SelB/Op encodings, PC_W/DATA_W defaults.
- Sub-module bip_decoder: combinational map from opcode to {SelA, SelB, Op, WrAcc_en, WrRam_en, RdRam_en, is_hlt}. The FSM gates these enables with the state.

## Test plan
- Program LDI 5; ADDI 3; STO 2; HLT with Start pulse -> WrAcc in EXEC of instructions 0 and 1 (SelA 01, then 10/SelB 1/Op 0); WrRam with DataAddr=2 in cycle 12; Done in cycle 16; CycleCount=15.
- SUBI 0x7FF -> Imm=0xFFFF, SelB=1, Op=1. LDI 0x3FF -> Imm=0x03FF.
- LD 7; SUB 8; HLT -> RdRam high in MEM with DataAddr 7, then DataAddr 8; SelA 00, then SelA 10/SelB 0/Op 1.
- Opcode 11111 -> 4 cycles, no strobes, ProgAddr advances by 1. Run without HLT from PC 0x7FF -> ProgAddr wraps to 0x000.
- Start held high during execution -> ignored, no PC reset. Reset asserted during EXEC of an ADD -> next cycle IDLE, WrAcc=0, PC=0, CycleCount=0, Busy=0.
- More than 65535 non-IDLE cycles -> CycleCount holds at 0xFFFF; next Start clears it to 0.
